wave_table_player: RTL and testbench
====================================

# wave_table_player

Parametrised sample-table playback source for the Goertzel datapath. Holds a loadable table of DATA_W-bit samples and emits them at a programmable sample rate derived from the system clock (e.g. 130 MHz / 100 = 1.3 MHz). Supports loop and one-shot modes, programmable length, a valid/ready output handshake and sticky overrun detection. Feeds the fixed/floating-point front end of the detector chain and doubles as the stimulus source in system benches.

## Interface
- DATA_W, 32, sample width
- DEPTH, 520, table entries
- ADDR_W, 10, address width (2^ADDR_W >= DEPTH)
- DIV_W, 16, width of sample-period divider

- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- wr_en  in  1  table write strobe
- wr_addr  in  ADDR_W  table write address (>= DEPTH ignored)
- wr_data  in  DATA_W  table write data
- start  in  1  begin playback (pulse)
- stop  in  1  abort playback (pulse)
- loop_mode  in  1  1 = wrap to 0 after last entry, 0 = one-shot
- length  in  ADDR_W  samples per pass, 1..DEPTH
- div  in  DIV_W  clocks per sample
- out_data  out  DATA_W  sample
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_last  out  1  qualifies out_data as table entry length-1
- busy  out  1  state != IDLE
- overrun  out  1  sticky: unaccepted sample overwritten

## Operation
- Table: single-port-write / registered-read RAM, read-first on same-address collision. Writes accepted in any state. Contents not cleared by reset.
- States: IDLE, RUN, FLUSH.
- IDLE: start (and not stop) with length != 0 -> RUN; latches length (clamped to DEPTH), div (0 treated as 1), loop_mode; addr = 0, tick counter = 0, overrun cleared. length == 0 -> start ignored.
- RUN: tick when counter == 0; counter reloads div-1, else decrements. On tick issue read of addr, tag last = (addr == length-1); addr increments, wraps to 0 after length-1.
- One-shot: tick on last entry -> FLUSH. Loop: stays in RUN.
- FLUSH: waits until the last sample is accepted or overwritten-free drained (out_valid low), then -> IDLE.
- Output register: read data loads out_data/out_last and sets out_valid one cycle after its read issue. If out_valid & !out_ready at load: overwrite, overrun <= 1. If out_valid & out_ready at load: old accepted, new loaded, no overrun. Accept without load clears out_valid.
- start while busy: ignored. stop in any state (priority over start): next edge -> IDLE, in-flight read discarded, out_valid and out_last cleared; overrun retained.
- Reset (any state, mid-run included): IDLE, addr 0, counter 0, out_data 0, out_valid 0, out_last 0, overrun 0, busy 0.

## Timing
- start sampled at edge E0 -> busy high after E0; first read issued at E1; out_valid high after E2 (latency 2).
- Subsequent samples every div clocks exactly, independent of out_ready.
- div = 1: one sample per clock; sustained throughput needs out_ready held high.
- One-shot: busy falls the edge after the last sample is accepted.
- Changes to length/div/loop_mode during RUN have no effect until next start.

## Test plan
- Load sine table 0..519, length 520, div 100, loop, out_ready=1 -> out_data = mem[0..519], mem[0].. with 100-cycle spacing, out_last on every mem[519], overrun stays 0.
- One-shot, length 4, div 1, out_ready=1 -> out_valid high 4 consecutive cycles from E2, out_last on 4th, busy low the edge after, addr resumes 0 on next start.
- out_ready=0, div 3, loop -> overrun=1 when second sample loads, out_data = mem[1]; next start clears overrun.
- stop asserted 50 cycles into a div-10 run; start+stop same cycle; start with length 0 -> IDLE next edge, out_valid 0, no further samples; length-0 start leaves busy 0.
- reset_n low for one cycle mid-run (out_valid high) -> all outputs 0 next edge, table contents preserved on restart.
- Write mem[5] on the same cycle it is read -> old value emitted; next pass emits new value.

Source files
------------

// File: rtl/wave_table_player.sv
// wave_table_player
//   Loadable sample table played back at a programmable rate (div clocks per
//   sample), loop or one-shot, with a valid/ready output and sticky overrun.
//
// Ports
//   clock, reset_n         : rising-edge clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data  : table write port (addresses >= DEPTH ignored)
//   start, stop            : playback control pulses (stop has priority)
//   loop_mode, length, div : playback setup, latched on accepted start
//   out_data/out_valid/out_ready/out_last : sample output handshake
//   busy                   : playback active (RUN or FLUSH)
//   overrun                : sticky, an unaccepted sample was overwritten
module wave_table_player #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 520,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_mode,
    input  logic [ADDR_W-1:0] length,
    input  logic [DIV_W-1:0]  div,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] last_addr;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_q;
    logic              loop_q;
    logic              rd_pend;
    logic              rd_last;

    logic go;
    logic tick;
    logic at_last;

    assign last_addr = len_q - ADDR_W'(1);
    assign at_last   = (addr == last_addr);
    assign go        = (state == IDLE) && start && !stop && (length != '0);
    assign tick      = (state == RUN) && (cnt == '0) && !stop;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (go) state_nx = RUN;
            RUN: begin
                if (stop)                         state_nx = IDLE;
                else if (tick && at_last && !loop_q) state_nx = FLUSH;
            end
            // Leave only once the final read has landed and been taken.
            FLUSH: if (stop || (!rd_pend && !out_valid)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Table: no reset, read-first on a same-cycle write to the read address.
    always_ff @(posedge clock) begin
        if (wr_en && (wr_addr < DEPTH_A)) mem[wr_addr] <= wr_data;
        if (tick)                         rd_data <= mem[addr];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            addr      <= '0;
            cnt       <= '0;
            len_q     <= '0;
            div_q     <= '0;
            loop_q    <= 1'b0;
            rd_pend   <= 1'b0;
            rd_last   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (tick) begin
                rd_last <= at_last;
                addr    <= at_last ? '0 : addr + ADDR_W'(1);
                cnt     <= div_q - DIV_W'(1);
            end else if ((state == RUN) && (cnt != '0)) begin
                cnt <= cnt - DIV_W'(1);
            end
            rd_pend <= tick;

            if (stop) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (rd_pend) begin
                out_data  <= rd_data;
                out_last  <= rd_last;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (go) begin
                len_q   <= (length > DEPTH_A) ? DEPTH_A : length;
                div_q   <= (div == '0) ? DIV_W'(1) : div;
                loop_q  <= loop_mode;
                addr    <= '0;
                cnt     <= '0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wave_table_player.sv
module tb_wave_table_player;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 520;
    localparam int ADDR_W = 10;
    localparam int DIV_W  = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              stop;
    logic              loop_mode;
    logic [ADDR_W-1:0] length;
    logic [DIV_W-1:0]  div;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              overrun;

    wave_table_player #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DIV_W (DIV_W)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .stop     (stop),
        .loop_mode(loop_mode),
        .length   (length),
        .div      (div),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    logic [DATA_W-1:0] mem_m [DEPTH];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic load_table();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(i);
            wr_data = $urandom;
            mem_m[i] = wr_data;
            tick_edge();
        end
        wr_en = 1'b0;
    endtask

    // Starts playback and checks every cycle against the timeline implied
    // by the rules: sample k appears after edge 2 + k*div (start edge = 0),
    // value table[k mod length]. Optional table write lands at edge wr_at.
    task automatic run_play(input int len_in, input int div_in, input bit loop_in,
                            input int ncyc_loop, input int wr_at, input int wr_a,
                            input logic [DATA_W-1:0] wr_d);
        int l, d, busy_end, ncyc, k, idx;
        bit valid_e, busy_e;
        logic [DATA_W-1:0] old_val;
        logic [DATA_W-1:0] exp_d;
        l = (len_in > DEPTH) ? DEPTH : len_in;
        d = (div_in == 0) ? 1 : div_in;
        busy_end = 2 + (l - 1) * d + 1;
        ncyc = loop_in ? ncyc_loop : busy_end + 3;
        old_val = '0;
        if (wr_at >= 0) begin
            old_val = mem_m[wr_a];
            mem_m[wr_a] = wr_d;
        end
        out_ready = 1'b1;
        start     = 1'b1;
        length    = ADDR_W'(len_in);
        div       = DIV_W'(div_in);
        loop_mode = loop_in;
        for (int n = 0; n <= ncyc; n++) begin
            tick_edge();
            valid_e = (n >= 2) && ((n - 2) % d == 0) && (loop_in || ((n - 2) / d < l));
            busy_e  = loop_in || (n <= busy_end);
            check("busy", busy, busy_e);
            check("valid", out_valid, valid_e);
            check("overrun", overrun, 1'b0);
            if (valid_e) begin
                k   = (n - 2) / d;
                idx = k % l;
                exp_d = (wr_at >= 0 && idx == wr_a && (n - 1) <= wr_at) ? old_val : mem_m[idx];
                check("data", out_data, exp_d);
                check("last", out_last, idx == l - 1);
            end
            // Setup changes and extra starts while busy must be ignored.
            start     = busy_e ? 1'($urandom % 2) : 1'b0;
            length    = ADDR_W'($urandom);
            div       = DIV_W'($urandom);
            loop_mode = 1'($urandom % 2);
            wr_en     = (wr_at >= 0) && (n + 1 == wr_at);
            wr_addr   = ADDR_W'(wr_a);
            wr_data   = wr_d;
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (loop_in) begin
            stop = 1'b1;
            tick_edge();
            stop = 1'b0;
            check("stop_busy", busy, 1'b0);
            check("stop_valid", out_valid, 1'b0);
        end
    endtask

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; loop_mode = 1'b0; length = '0; div = '0;
        out_ready = 1'b1;
        tick_edge();
        tick_edge();
        check("rst_busy", busy, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, '0);
        check("rst_last", out_last, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        reset_n = 1'b1;
        tick_edge();

        load_table();

        // Full-table loop at div 100, past one wrap.
        run_play(520, 100, 1'b1, 52300, -1, 0, '0);

        // One-shot length 4 div 1, twice (address restarts at 0).
        run_play(4, 1, 1'b0, 0, -1, 0, '0);
        run_play(4, 1, 1'b0, 0, -1, 0, '0);

        // Length above DEPTH clamps to DEPTH.
        run_play(1000, 1, 1'b0, 0, -1, 0, '0);

        // Randomised setups, div 0 included.
        for (int r = 0; r < 12; r++)
            run_play($urandom_range(1, 24), $urandom_range(0, 5), 1'($urandom % 2),
                     $urandom_range(20, 80), -1, 0, '0);

        // Overrun with consumer stalled.
        out_ready = 1'b0;
        start = 1'b1; length = 10'd8; div = 16'd3; loop_mode = 1'b1;
        for (int n = 0; n <= 5; n++) begin
            tick_edge();
            start = 1'b0;
            if (n == 2) begin
                check("ovr_v2", out_valid, 1'b1);
                check("ovr_d2", out_data, mem_m[0]);
                check("ovr_o2", overrun, 1'b0);
            end
            if (n == 5) begin
                check("ovr_d5", out_data, mem_m[1]);
                check("ovr_o5", overrun, 1'b1);
            end
        end
        stop = 1'b1;
        tick_edge();
        stop = 1'b0;
        check("ovr_kept", overrun, 1'b1);
        check("ovr_stop_valid", out_valid, 1'b0);
        run_play(3, 2, 1'b0, 0, -1, 0, '0);

        // Stop 50 cycles into a div-10 run.
        out_ready = 1'b1;
        start = 1'b1; length = 10'd20; div = 16'd10; loop_mode = 1'b1;
        tick_edge();
        start = 1'b0;
        for (int n = 1; n < 50; n++) tick_edge();
        stop = 1'b1;
        tick_edge();
        stop = 1'b0;
        check("stop50_busy", busy, 1'b0);
        check("stop50_valid", out_valid, 1'b0);
        check("stop50_last", out_last, 1'b0);
        for (int n = 0; n < 30; n++) begin
            tick_edge();
            check("stop50_quiet", {busy, out_valid}, 2'b00);
        end

        // start and stop together.
        start = 1'b1; stop = 1'b1; length = 10'd5; div = 16'd1;
        tick_edge();
        start = 1'b0; stop = 1'b0;
        for (int n = 0; n < 5; n++) begin
            check("ss_quiet", {busy, out_valid}, 2'b00);
            tick_edge();
        end

        // start with length 0.
        start = 1'b1; length = '0; div = 16'd1;
        tick_edge();
        start = 1'b0;
        for (int n = 0; n < 5; n++) begin
            check("len0_quiet", {busy, out_valid}, 2'b00);
            tick_edge();
        end

        // Reset mid-run with out_valid high.
        start = 1'b1; length = 10'd10; div = 16'd1; loop_mode = 1'b1;
        tick_edge();
        start = 1'b0;
        for (int n = 1; n <= 5; n++) tick_edge();
        check("pre_rst_valid", out_valid, 1'b1);
        reset_n = 1'b0;
        tick_edge();
        reset_n = 1'b1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, '0);
        check("mid_rst_last", out_last, 1'b0);
        check("mid_rst_overrun", overrun, 1'b0);
        run_play(10, 1, 1'b0, 0, -1, 0, '0);

        // Write entry 5 on the edge it is read: old value first, new next pass.
        run_play(8, 1, 1'b1, 20, 6, 5, 32'hA5A5_1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
